// File: rtl/cpu_out_collector_pkg.sv
// cpu_io_pkg: shared types and constants for the CPU output collector.
//   collector_state_t : run-controller states (IDLE, RUN, DRAIN, DONE)
//   CPU_WORD_WIDTH    : default CPU output word width in bits
//   is_busy()         : decode of the states reported on the busy output
package cpu_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } collector_state_t;

    localparam int CPU_WORD_WIDTH = 36;

    function automatic logic is_busy(input collector_state_t st);
        return (st == RUN) || (st == DRAIN);
    endfunction

endpackage

// File: rtl/cpu_out_collector_if.sv
// cpu_out_collector_if: host-side output stream of the collector.
//   outValid : FIFO holds at least one word (collector -> host)
//   outReady : host accepts outData this cycle (host -> collector)
//   outData  : FIFO head word, show-ahead (collector -> host)
// master = collector side, slave = host side.
interface cpu_out_collector_if #(
    parameter int WIDTH = cpu_io_pkg::CPU_WORD_WIDTH
) ();
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;

    modport master (output outValid, output outData, input outReady);
    modport slave  (input outValid, input outData, output outReady);
endinterface

// File: rtl/cpu_out_collector_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and show-ahead head.
//   clock, reset (async active-low)
//   push, push_data : write request/data; accepted when not full, or when
//                     full and a pop happens in the same cycle
//   pop             : remove head word; ignored while empty
//   full, empty     : occupancy flags
//   count           : exact number of words held, 0..DEPTH
//   head            : word at the read pointer
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = {CW{1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             accept_s;

    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == CNT_EMPTY);
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign pop_s    = pop && !empty;
    assign accept_s = push && (!full || pop_s);

    // Storage array; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cpu_out_collector.sv
// cpu_out_collector: run controller and output buffer for the CPU core.
// Starts a CPU run, captures every flagged CPU output word into a FIFO and
// lets the host drain it over a valid/ready handshake. The run ends on
// cpuHalt, or also on an idle timeout when COLLECTOR_TIMEOUT_EN is defined.
// Ports:
//   clock, reset (async active-low)
//   startIO    : host start pulse, honoured in IDLE and DONE
//   cpuStart   : high while in RUN
//   cpuOutFlag, cpuOut : CPU output strobe and word
//   cpuHalt    : CPU end of program
//   host       : outValid/outReady/outData stream (master modport)
//   count      : words held in the FIFO
//   busy       : RUN or DRAIN
//   overflow   : sticky, a word was dropped on a full FIFO
//   endFlag    : DONE
// Build option: COLLECTOR_TIMEOUT_EN enables the idle counter/timeout.
module cpu_out_collector
    import cpu_io_pkg::*;
#(
    parameter int WIDTH   = CPU_WORD_WIDTH,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       startIO,
    output logic                       cpuStart,
    input  logic                       cpuOutFlag,
    input  logic [WIDTH-1:0]           cpuOut,
    input  logic                       cpuHalt,
    cpu_out_collector_if.master        host,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       overflow,
    output logic                       endFlag
);
    localparam int CW = $clog2(DEPTH + 1);

    collector_state_t state_r;
    collector_state_t state_next_s;

    logic             push_s;
    logic             pop_s;
    logic             start_run_s;
    logic             timeout_hit_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [WIDTH-1:0] fifo_head_s;
    logic             cpu_start_r;
    logic             busy_r;
    logic             end_flag_r;
    logic             overflow_r;

    assign push_s      = (state_r == RUN) && cpuOutFlag;
    assign pop_s       = !fifo_empty_s && host.outReady;
    assign start_run_s = ((state_r == IDLE) || (state_r == DONE)) && startIO;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (cpuOut),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

`ifdef COLLECTOR_TIMEOUT_EN
    localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    logic [IW-1:0] idle_cnt_r;

    // Idle counter: silent RUN cycles since run start or the last push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (start_run_s) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (state_r == RUN) begin
            idle_cnt_r <= push_s ? {IW{1'b0}} : (idle_cnt_r + IDLE_ONE);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Fires on the TIMEOUT-th consecutive silent RUN cycle.
    assign timeout_hit_s = (state_r == RUN) && !push_s && (idle_cnt_r == IDLE_LAST);
`else
    // Timeout detection is compiled out; this compare is constant false.
    assign timeout_hit_s = (TIMEOUT < 0);
`endif

    // Next-state logic for the run controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (startIO) state_next_s = RUN;
                else         state_next_s = IDLE;
            end
            RUN: begin
                if (cpuHalt || timeout_hit_s) state_next_s = DRAIN;
                else                          state_next_s = RUN;
            end
            DRAIN: begin
                // Registered count: the last pop shows here one cycle later.
                if (fifo_count_s == {CW{1'b0}}) state_next_s = DONE;
                else                            state_next_s = DRAIN;
            end
            DONE: begin
                if (startIO) state_next_s = RUN;
                else         state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and status outputs registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cpu_start_r <= 1'b0;
            busy_r      <= 1'b0;
            end_flag_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cpu_start_r <= (state_next_s == RUN);
            busy_r      <= is_busy(state_next_s);
            end_flag_r  <= (state_next_s == DONE);
        end
    end

    // Sticky overflow: cleared when a run starts, set on a dropped word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (start_run_s) begin
            overflow_r <= 1'b0;
        end else if (push_s && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign cpuStart      = cpu_start_r;
    assign busy          = busy_r;
    assign endFlag       = end_flag_r;
    assign overflow      = overflow_r;
    assign count         = fifo_count_s;
    assign host.outValid = !fifo_empty_s;
    assign host.outData  = fifo_head_s;

endmodule

// File: tb/tb_cpu_out_collector.sv
// Testbench for cpu_out_collector (WIDTH=36, DEPTH=4, TIMEOUT=8).
// A queue-based reference model tracks run phase, buffered words and the
// overflow flag; every cycle all DUT outputs are compared against it.
module tb_cpu_out_collector;
    localparam int W  = 36;
    localparam int D  = 4;
    localparam int T  = 8;
    localparam int CW = $clog2(D + 1);

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          startIO;
    logic          cpuStart;
    logic          cpuOutFlag;
    logic [W-1:0]  cpuOut;
    logic          cpuHalt;
    logic [CW-1:0] count;
    logic          busy;
    logic          overflow;
    logic          endFlag;

    cpu_out_collector_if #(.WIDTH(W)) host ();

    cpu_out_collector #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TIMEOUT (T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .startIO    (startIO),
        .cpuStart   (cpuStart),
        .cpuOutFlag (cpuOutFlag),
        .cpuOut     (cpuOut),
        .cpuHalt    (cpuHalt),
        .host       (host),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow),
        .endFlag    (endFlag)
    );

    always #5 clock = ~clock;

    int           checks = 0;
    int           errors = 0;
    int           ms     = M_IDLE;
    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    logic [W-1:0] sent[$];
    bit           movf   = 1'b0;
    int           silent = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cpuStart", {63'd0, cpuStart}, {63'd0, ms == M_RUN});
        chk("busy", {63'd0, busy}, {63'd0, (ms == M_RUN) || (ms == M_DRAIN)});
        chk("endFlag", {63'd0, endFlag}, {63'd0, ms == M_DONE});
        chk("overflow", {63'd0, overflow}, {63'd0, movf});
        chk("count", {61'd0, count}, 64'(mq.size()));
        chk("outValid", {63'd0, host.outValid}, {63'd0, mq.size() > 0});
        if (mq.size() > 0) chk("outData", {28'd0, host.outData}, {28'd0, mq[0]});
    endtask

    task automatic model_reset();
        ms = M_IDLE;
        mq.delete();
        movf   = 1'b0;
        silent = 0;
    endtask

    // One clock: the model applies the rules to the inputs seen at the edge.
    task automatic step();
        int n_pre;
        bit pop;
        bit push;
        bit to;
        n_pre = mq.size();
        pop   = (n_pre > 0) && host.outReady;
        push  = (ms == M_RUN) && cpuOutFlag;
        to    = 1'b0;
        if (pop) got.push_back(mq.pop_front());
        if (push) begin
            if (n_pre < D || pop) begin
                mq.push_back(cpuOut);
                sent.push_back(cpuOut);
            end else begin
                movf = 1'b1;
            end
        end
        case (ms)
            M_IDLE, M_DONE: if (startIO) begin ms = M_RUN; movf = 1'b0; silent = 0; end
            M_RUN: begin
                silent = push ? 0 : silent + 1;
`ifdef COLLECTOR_TIMEOUT_EN
                to = (silent == T);
`endif
                if (cpuHalt || to) ms = M_DRAIN;
            end
            M_DRAIN: if (n_pre == 0) ms = M_DONE;
            default: ms = M_IDLE;
        endcase
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic cyc(input bit s, input bit f, input logic [W-1:0] d, input bit h, input bit r);
        startIO     = s;
        cpuOutFlag  = f;
        cpuOut      = d;
        cpuHalt     = h;
        host.outReady = r;
        step();
    endtask

    task automatic drain_to_done(input int bound, input bit random_ready);
        for (int i = 0; i < bound; i++) begin
            if (ms == M_DONE) break;
            cyc(1'b0, 1'b0, '0, 1'b0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        chk("reach_done", {63'd0, endFlag}, 64'd1);
    endtask

    task automatic check_reset_values();
        chk("rst_cpuStart", {63'd0, cpuStart}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_endFlag", {63'd0, endFlag}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_outValid", {63'd0, host.outValid}, 64'd0);
        chk("rst_outData", {28'd0, host.outData}, 64'd0);
    endtask

    initial begin
        int n_words;
        int waited;
        logic [W-1:0] w;

        // Reset state
        reset = 1'b0; startIO = 1'b0; cpuOutFlag = 1'b0; cpuOut = '0;
        cpuHalt = 1'b0; host.outReady = 1'b0;
        model_reset();
        #12;
        check_reset_values();
        reset = 1'b1;

        // Basic run: 1, 2, 3 then halt, host always ready
        got.delete();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 36'h1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 36'h2, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 36'h3, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        drain_to_done(20, 1'b0);
        chk("basic_n", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("basic_word", {28'd0, got[i]}, 64'(i + 1));

        // Overflow: six pushes into a four-deep FIFO with no reads
        got.delete();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 36'hA0 + 36'(i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("ovf_count", {61'd0, count}, 64'd4);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        drain_to_done(20, 1'b0);
        chk("ovf_n", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("ovf_word", {28'd0, got[i]}, 64'h A0 + 64'(i));

        // Full plus simultaneous push/pop
        got.delete();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 36'hC0 + 36'(i), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 36'hB0, 1'b0, 1'b1);
        chk("full_pp_count", {61'd0, count}, 64'd4);
        chk("full_pp_ovf", {63'd0, overflow}, 64'd0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drain_to_done(20, 1'b0);
        chk("full_pp_n", 64'(got.size()), 64'd5);
        if (got.size() == 5) chk("full_pp_b0", {28'd0, got[4]}, 64'hB0);

        // Idle timeout (or its absence)
        got.delete();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 36'h55, 1'b0, 1'b0);
        waited = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
            waited = i;
            if (!cpuStart) break;
        end
`ifdef COLLECTOR_TIMEOUT_EN
        chk("timeout_cycles", 64'(waited), 64'(T));
`else
        chk("no_timeout_run", {63'd0, cpuStart}, 64'd1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
`endif
        drain_to_done(20, 1'b0);

        // Random backpressure over 50 words
        got.delete();
        sent.delete();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        n_words = 0;
        for (int i = 0; i < 2000 && n_words < 50; i++) begin
            bit f;
            f = ($urandom_range(0, 3) == 0) && (mq.size() < D);
            w = {4'h0, 32'($urandom)};
            cyc(1'b0, f, w, 1'b0, $urandom_range(0, 3) != 0);
            if (f) n_words++;
        end
        chk("bp_pushed", 64'(n_words), 64'd50);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
        drain_to_done(500, 1'b1);
        chk("bp_ovf", {63'd0, overflow}, 64'd0);
        chk("bp_n", 64'(got.size()), 64'(sent.size()));
        for (int i = 0; i < got.size() && i < sent.size(); i++) chk("bp_word", {28'd0, got[i]}, {28'd0, sent[i]});

        // Reset in the middle of DRAIN with three words buffered
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 36'hD0 + 36'(i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("drain_before_rst", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        #3;
        reset = 1'b1;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("clean_run_count", {61'd0, count}, 64'd0);
        chk("clean_run_busy", {63'd0, busy}, 64'd1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drain_to_done(10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
